booth_rad4_seq_mult: RTL and testbench
======================================

// Module: booth_rad4_seq_mult
// PURPOSE
//  Iterative radix-4 modified-Booth multiplier, parametrised in operand width; one Booth digit per clock.
//  Signed/unsigned selectable per operation; valid/ready on both sides; sits beside the combinational array as the low-area multiplier.
//  Operands latched on accept; exact 2*W-bit product held until consumed.
// PARAMETERS
//  W      11   operand width in bits (>=4)
//  EW     W+1 rounded up to even   extended multiplier width (localparam)
//  NDIG   EW/2                     Booth digits per operation (localparam; 6 for W=11)
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     asynchronous reset, active low
//  in_valid   in   1     operand set valid
//  in_ready   out  1     block idle, can accept
//  in_signed  in   1     1: a,b two's complement; 0: unsigned (sampled with operands)
//  a          in   W     multiplicand
//  b          in   W     multiplier (Booth-recoded)
//  out_valid  out  1     product valid
//  out_ready  in   1     consumer accepts product
//  p          out  2*W   product a*b (two's complement if signed)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, in_ready=1, out_valid=0, p=0, accumulator/digit counter cleared; abandons any in-flight op.
//  - FSM: IDLE --(in_valid&&in_ready)--> RUN --(last digit | early term)--> DONE --(out_valid&&out_ready)--> IDLE.
//  - in_ready=1 only in IDLE; out_valid=1 only in DONE; no accept in the cycle a product is consumed.
//  - Accept: latch a (extended to W+2 bits, sign- or zero-extended per in_signed), b extended to EW bits same rule, prev bit=0, acc=0, idx=0.
//  - RUN cycle k: triplet {b[2k+1],b[2k],b[2k-1]} (b[-1]=0) -> digit {0,+1,+2,-1,-2}:
//    000/111->0; 001/010->+A; 011->+2A; 100->-2A; 101/110->-A.
//    Negative digits: add ones-complement of multiple plus neg carry-in (no separate subtractor).
//    acc += multiple << 2k; acc is signed 2*W+2 bits, p = acc[2*W-1:0].
//  - Fixed latency: out_valid rises NDIG cycles after the accept edge (6 for W=11).
//  - DONE: p and out_valid stable while out_ready=0; in_valid ignored; a/b/in_signed changes ignored while busy.
//  - Boundaries: signed min*min = 2^(2W-2) exact; unsigned max*max exact; b=0 still runs (see CONFIGURATION).
//  - out_ready with out_valid=0 has no effect.
// CONFIGURATION
//  BOOTH_SEQ_EARLY_TERM_EN defined:
//    After each RUN cycle, if all unprocessed bits of b plus the current prev bit are equal (all 0 or all 1), the remaining digits are zero.
//    In that case go to DONE next cycle; latency 1..NDIG.
//  Not defined: always exactly NDIG RUN cycles; products identical in both builds.
// STRUCTURE
//  - Package booth_rad4_pkg: booth_digit_e {BD_ZERO,BD_P1,BD_P2,BD_M1,BD_M2}; state_e {ST_IDLE,ST_RUN,ST_DONE};
//    function booth_ndig(int w) returning digit count.
//  - Sub-module booth_rad4_digit_enc (combinational): triplet + extended A -> booth_digit_e, neg, ones-complemented multiple (W+2 bits).
//  - Top: FSM, operand/accumulator registers, digit counter, early-term detect (under macro).
// TESTING (W=11)
//  1. unsigned a=2047,b=2047 -> p=4190209, out_valid exactly 6 cycles after accept (no EN).
//  2. signed a=-1024,b=-1024 -> p=22'h100000; signed a=5,b=-3 -> p=22'h3FFFF1.
//  3. out_ready=0 for 10 cycles in DONE -> p,out_valid stable, in_ready=0, in_valid pulses ignored; then handshake -> IDLE next cycle.
//  4. rst_n low during RUN cycle 3 -> out_valid=0,p=0 immediately; after release unsigned 100*7 -> p=700.
//  5. EARLY_TERM_EN: unsigned b=0 -> out_valid 1 cycle after accept; b=3 -> 2 cycles; signed b=-1 -> 1 cycle, p=-a; without EN all 6 cycles.
//  6. random 10k ops, both modes, random in_valid/out_ready stalls -> p matches reference a*b.

Source files
------------

// File: rtl/booth_rad4_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
package booth_rad4_pkg;

  typedef enum logic [2:0] {BD_ZERO, BD_P1, BD_P2, BD_M1, BD_M2} booth_digit_e;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  // W+1 bits rounded up to even, two bits per radix-4 digit
  function automatic int booth_ndig(input int w);
    return (w + 2) / 2;
  endfunction

endpackage

// File: rtl/booth_rad4_digit_enc.sv
// Radix-4 Booth digit encoder: multiplier triplet plus extended multiplicand in,
// digit, negate flag and ones-complemented multiple out (purely combinational).
module booth_rad4_digit_enc
  import booth_rad4_pkg::*;
#(
  parameter int W = 11
) (
  input  logic [2:0]   trip,
  input  logic [W+1:0] a_ext,
  output booth_digit_e digit,
  output logic         neg,
  output logic [W+1:0] mult
);

  always_comb begin
    digit = BD_ZERO;
    unique case (trip)
      3'b001, 3'b010: digit = BD_P1;
      3'b011:         digit = BD_P2;
      3'b100:         digit = BD_M2;
      3'b101, 3'b110: digit = BD_M1;
      default:        digit = BD_ZERO;
    endcase
  end

  // Negative multiples are ones-complemented here; the +1 enters the
  // accumulator adder as a carry-in at the digit's weight.
  always_comb begin
    neg  = 1'b0;
    mult = '0;
    case (digit)
      BD_P1: mult = a_ext;
      BD_P2: mult = {a_ext[W:0], 1'b0};
      BD_M1: begin
        mult = ~a_ext;
        neg  = 1'b1;
      end
      BD_M2: begin
        mult = ~{a_ext[W:0], 1'b0};
        neg  = 1'b1;
      end
      default: begin
        mult = '0;
        neg  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/booth_rad4_seq_mult.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready both sides.
// Optional early termination when the remaining multiplier bits are all-equal: BOOTH_SEQ_EARLY_TERM_EN.
module booth_rad4_seq_mult
  import booth_rad4_pkg::*;
#(
  parameter int W = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_signed,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p
);

  localparam int EW   = ((W + 2) / 2) * 2;
  localparam int NDIG = booth_ndig(W);
  localparam int AW   = W + 2;
  localparam int ACW  = 2 * W + 2;
  localparam int IW   = $clog2(NDIG);

  state_e          state_reg, state_next;
  logic [AW-1:0]   a_reg;
  logic [EW-1:0]   b_reg;
  logic            prev_reg;
  logic [ACW-1:0]  acc_reg;
  logic [IW-1:0]   idx_reg;

  booth_digit_e    digit;
  logic            neg;
  logic [AW-1:0]   mult;
  logic [ACW-1:0]  mult_ext;
  logic [ACW-1:0]  part;
  logic [ACW-1:0]  cin;
  logic [ACW-1:0]  acc_sum;
  logic [EW-1:0]   b_shift;
  logic            prev_shift;
  logic            last_digit;
  logic            run_done;
  logic            accept;

  booth_rad4_digit_enc #(.W(W)) u_enc (
    .trip  ({b_reg[1:0], prev_reg}),
    .a_ext (a_reg),
    .digit (digit),
    .neg   (neg),
    .mult  (mult)
  );

  assign mult_ext = {{(ACW - AW){mult[AW-1]}}, mult};
  assign part     = mult_ext << {idx_reg, 1'b0};
  assign cin      = ACW'(neg) << {idx_reg, 1'b0};
  assign acc_sum  = acc_reg + part + cin;

  // b is consumed two bits per cycle; shifting in copies of the top bit keeps
  // the register equal to the unprocessed bits padded with their own sign
  assign b_shift    = {{2{b_reg[EW-1]}}, b_reg[EW-1:2]};
  assign prev_shift = b_reg[1];
  assign last_digit = (idx_reg == IW'(NDIG - 1));

`ifdef BOOTH_SEQ_EARLY_TERM_EN
  logic rest_zero;
  logic rest_ones;
  assign rest_zero = (b_shift == '0) && !prev_shift;
  assign rest_ones = (&b_shift) && prev_shift;
  assign run_done  = last_digit || rest_zero || rest_ones;
`else
  assign run_done  = last_digit;
`endif

  assign accept = in_valid && in_ready;
  assign p      = acc_reg[2*W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (run_done) state_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      prev_reg <= 1'b0;
      acc_reg  <= '0;
      idx_reg  <= '0;
    end else if (accept) begin
      a_reg    <= in_signed ? {{2{a[W-1]}}, a} : {2'b00, a};
      b_reg    <= in_signed ? {{(EW - W){b[W-1]}}, b} : {{(EW - W){1'b0}}, b};
      prev_reg <= 1'b0;
      acc_reg  <= '0;
      idx_reg  <= '0;
    end else if (state_reg == ST_RUN) begin
      if (digit != BD_ZERO) acc_reg <= acc_sum;
      b_reg    <= b_shift;
      prev_reg <= prev_shift;
      idx_reg  <= idx_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_booth_rad4_seq_mult.sv
// Self-checking bench for booth_rad4_seq_mult (W=11): vector table, hold/reset
// sequences and randomised ops with a product scoreboard.
`timescale 1ns/1ps
module tb_booth_rad4_seq_mult;
  import booth_rad4_pkg::*;

  localparam int W    = 11;
  localparam int EW   = ((W + 2) / 2) * 2;
  localparam int NDIG = booth_ndig(W);
`ifdef BOOTH_SEQ_EARLY_TERM_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic           in_signed;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;

  booth_rad4_seq_mult #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [2*W-1:0] p;
    int             lat_en;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input bit ok, input string name, input longint act, input longint expv);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
    longint xv, yv;
    logic [63:0] r;
    xv = s ? longint'($signed(x)) : longint'(x);
    yv = s ? longint'($signed(y)) : longint'(y);
    r  = 64'(xv * yv);
    return r[2*W-1:0];
  endfunction

  // Latency from accept edge to out_valid: early exit once the remaining
  // multiplier bits and the last-consumed bit are all equal
  function automatic int exp_lat(input logic [W-1:0] y, input logic s);
    logic [EW-1:0] bx;
    bit pb, same;
    for (int i = 0; i < EW; i++) bx[i] = (i < W) ? y[i] : (s & y[W-1]);
    if (EN) begin
      for (int k = 0; k < NDIG - 1; k++) begin
        pb   = bx[2*k+1];
        same = 1'b1;
        for (int i = 2*k + 2; i < EW; i++) if (bx[i] != pb) same = 1'b0;
        if (same) return k + 1;
      end
    end
    return NDIG;
  endfunction

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                       input logic [2*W-1:0] exp_p, input int stall, input int hold,
                       input int lat_req, input string name);
    int cnt;
    int lat;
    logic [2*W-1:0] p0;
    logic [2*W-1:0] e;
    repeat (stall) @(negedge clk);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb_v;
    in_signed = ts;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk(in_ready, {name, "_accept_timeout"}, longint'(in_ready), 1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(exp_p);
    @(negedge clk);
    in_valid  = 1'b0;
    a         = W'($urandom);
    b         = W'($urandom);
    in_signed = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      out_ready = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    out_ready = 1'b0;
    chk(out_valid, {name, "_out_timeout"}, longint'(out_valid), 1);
    if (!out_valid) return;
    chk(lat == lat_req, {name, "_latency"}, longint'(lat), longint'(lat_req));
    p0 = p;
    e  = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk(p == e, {name, "_product"}, longint'(p), longint'(e));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      a        = W'($urandom);
      b        = W'($urandom);
      @(negedge clk);
      chk(out_valid && !in_ready && p == p0, {name, "_hold_stable"}, longint'(p), longint'(p0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk(!out_valid && in_ready, {name, "_back_to_idle"},
        longint'({out_valid, in_ready}), 64'h1);
    $display("op %s a=%0h b=%0h s=%0d p=%0h lat=%0d", name, ta, tb_v, ts, p0, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t expected end earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{11'd2047, 11'd2047, 1'b0, 22'h3FF001, 6};
    tbl[1]  = '{11'h400,  11'h400,  1'b1, 22'h100000, 6};
    tbl[2]  = '{11'd5,    11'h7FD,  1'b1, 22'h3FFFF1, 2};
    tbl[3]  = '{11'd100,  11'd7,    1'b0, 22'd700,    2};
    tbl[4]  = '{11'd1234, 11'd0,    1'b0, 22'd0,      1};
    tbl[5]  = '{11'd37,   11'd3,    1'b0, 22'd111,    2};
    tbl[6]  = '{11'd123,  11'h7FF,  1'b1, 22'h3FFF85, 1};
    tbl[7]  = '{11'h400,  11'd1023, 1'b1, 22'h300400, 6};
    tbl[8]  = '{11'd2047, 11'd1,    1'b0, 22'h0007FF, 1};
    tbl[9]  = '{11'h7FF,  11'h7FF,  1'b1, 22'd1,      1};
    tbl[10] = '{11'd1024, 11'd1024, 1'b0, 22'h100000, 6};
    tbl[11] = '{11'd1023, 11'd1023, 1'b1, 22'h0FF801, 6};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk(in_ready && !out_valid && p == '0, "reset_state",
        longint'({in_ready, out_valid, p}), longint'({1'b1, 1'b0, 22'd0}));
    rst_n = 1'b1;
    @(negedge clk);

    // out_ready while nothing is valid must not disturb the idle block
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk(!out_valid && in_ready, "idle_out_ready", longint'({out_valid, in_ready}), 64'h1);
    end
    out_ready = 1'b0;

    for (int i = 0; i < 12; i++)
      do_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].p, 0, 0,
            EN ? tbl[i].lat_en : NDIG, $sformatf("tbl%0d", i));

    do_op(11'd1500, 11'd3, 1'b0, 22'd4500, 1, 10, EN ? 2 : NDIG, "hold10");

    // Abort mid-operation with an asynchronous reset
    @(negedge clk);
    in_valid  = 1'b1;
    a         = 11'd2000;
    b         = 11'd1500;
    in_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk(!out_valid && in_ready && p == '0, "async_reset_abort",
        longint'({out_valid, in_ready, p}), longint'({1'b0, 1'b1, 22'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(11'd100, 11'd7, 1'b0, 22'd700, 0, 0, EN ? 2 : NDIG, "after_reset");

    for (int i = 0; i < 2000; i++) begin
      logic [W-1:0] ra, rb;
      logic rs;
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = '1;
        2: ra = {1'b1, {(W-1){1'b0}}};
        default: ;
      endcase
      rs = 1'($urandom);
      do_op(ra, rb, rs, ref_mult(ra, rb, rs), $urandom_range(0, 3), $urandom_range(0, 3),
            exp_lat(rb, rs), $sformatf("rnd%0d", i));
    end

    chk(exp_q.size() == 0, "scoreboard_empty", longint'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
